// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential PC generation, single-outstanding ibus requests and a
// DEPTH-entry {pc,instr} FIFO toward decode. Optional FETCH_ALIGN_CHECK_EN adds misaligned-PC trapping.
package fetch_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        out_adel
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DROP} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic          r_drop;
  logic          r_ireq_valid;
  logic [31:0]   r_ireq_addr;

  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic          w_bus_push;
  logic          w_push;
  logic          w_pop;
  logic          w_can_issue;
  logic [31:0]   w_push_instr;

`ifdef FETCH_ALIGN_CHECK_EN
  logic          r_mem_adel [DEPTH];
  logic          r_halt;
  logic          w_misaligned;
  logic          w_align_push;

  assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);
  assign w_align_push = (r_state == S_IDLE) && !redirect_valid && w_misaligned &&
                        !r_halt && (r_count < C_DEPTH);
  assign w_can_issue  = (r_count < C_DEPTH) && !w_misaligned;
  assign w_push       = w_bus_push || w_align_push;
  assign w_push_instr = w_align_push ? 32'h0 : iresp.data;
  assign out_adel     = r_mem_adel[r_rd_ptr];
`else
  assign w_can_issue  = (r_count < C_DEPTH);
  assign w_push       = w_bus_push;
  assign w_push_instr = iresp.data;
`endif

  // A response only lands in the FIFO if no redirect arrives with it and it was not squashed.
  assign w_bus_push = !redirect_valid &&
                      (((r_state == S_ADDR) && iresp.addr_ok && iresp.data_ok && !r_drop) ||
                       ((r_state == S_DATA) && iresp.data_ok));
  assign w_pop      = out_valid && out_ready;

  assign ireq.valid = r_ireq_valid;
  assign ireq.addr  = r_ireq_addr;
  assign out_valid  = (r_count != '0);
  assign out_pc     = r_mem_pc[r_rd_ptr];
  assign out_instr  = r_mem_instr[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_drop       <= 1'b0;
      r_ireq_valid <= 1'b0;
      r_ireq_addr  <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_halt       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_drop <= 1'b0;
          if (!redirect_valid && w_can_issue) begin
            r_state      <= S_ADDR;
            r_ireq_valid <= 1'b1;
            r_ireq_addr  <= r_fetch_pc;
          end
        end
        S_ADDR: begin
          if (iresp.addr_ok) begin
            r_ireq_valid <= 1'b0;
            if (iresp.data_ok) begin
              r_state <= S_IDLE;
              r_drop  <= 1'b0;
            end else if (r_drop || redirect_valid) begin
              r_state <= S_DROP;
            end else begin
              r_state <= S_DATA;
            end
          end
          if (redirect_valid && !(iresp.addr_ok && iresp.data_ok)) r_drop <= 1'b1;
        end
        S_DATA: begin
          if (iresp.data_ok) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
          end else if (redirect_valid) begin
            r_state <= S_DROP;
            r_drop  <= 1'b1;
          end
        end
        S_DROP: begin
          if (iresp.data_ok) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_bus_push) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (redirect_valid) r_fetch_pc <= redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
      // Once the error entry is queued, fetch stays parked until a redirect supplies a new PC.
      if (redirect_valid) r_halt <= 1'b0;
      else if (w_align_push) r_halt <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= 32'h0;
        r_mem_instr[i] <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
        r_mem_adel[i]  <= 1'b0;
`endif
      end
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
        r_mem_instr[r_wr_ptr] <= w_push_instr;
`ifdef FETCH_ALIGN_CHECK_EN
        r_mem_adel[r_wr_ptr]  <= w_align_push;
`endif
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
